// File: rtl/nonogram_line_engine.sv
// Nonogram line engine. It filters each line's candidate options against the board,
// requeues the options that survive, and commits the cells on which all survivors agree.
module nonogram_line_engine #(
  parameter int SIZE  = 11,
  parameter int CNT_W = 7
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 start,
  input  logic [3:0]           num_rows,
  input  logic [3:0]           num_cols,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic                 in_hdr,
  input  logic [SIZE-1:0]      in_data,
  input  logic [CNT_W-1:0]     in_cnt,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [SIZE-1:0]      out_data,
  output logic                 out_hdr,
  output logic [CNT_W-1:0]     new_cnt,
  output logic                 cnt_valid,
  output logic [SIZE*SIZE-1:0] known,
  output logic [SIZE*SIZE-1:0] assigned,
  output logic                 solved,
  output logic                 err_contra,
  output logic                 err_line
);

  localparam int CELLS = SIZE * SIZE;

  typedef enum logic [1:0] {IDLE, HDR, ACC, COMMIT} state_t;

  state_t           state;
  logic [3:0]       rows_q, cols_q, line_idx;
  logic             line_is_col;
  logic [SIZE-1:0]  and_acc, or_acc;
  logic [CNT_W-1:0] surv, remaining;

  function automatic logic [SIZE-1:0] reverse_bits(input logic [SIZE-1:0] v);
    for (int k = 0; k < SIZE; k++) reverse_bits[k] = v[SIZE-1-k];
  endfunction

  function automatic logic [CELLS-1:0] spread_col(input logic [SIZE-1:0] v);
    spread_col = '0;
    for (int k = 0; k < SIZE; k++) spread_col[k*SIZE] = v[k];
  endfunction

  function automatic logic [SIZE-1:0] gather_col(input logic [CELLS-1:0] v);
    for (int k = 0; k < SIZE; k++) gather_col[k] = v[k*SIZE];
  endfunction

  // All line vectors are in cell order: bit k is cell k of the current line.
  logic [3:0]       line_len;
  logic [SIZE-1:0]  len_mask, opt_cell, line_known, line_assigned, agree;
  logic [CELLS-1:0] known_sh, assigned_sh, commit_mask, commit_val, region;
  logic [SIZE-1:0]  rows_ext, cols_ext;
  logic [3:0]       col_off, hdr_idx;
  logic             hdr_is_col, hdr_bad, consistent, fire;

  // NOTE: every variable gets a default at the top of always_comb so no path infers a latch.
  always_comb begin
    line_len      = line_is_col ? rows_q : cols_q;
    len_mask      = ~({SIZE{1'b1}} << line_len);
    opt_cell      = reverse_bits(in_data) >> (SIZE - int'(line_len));
    known_sh      = line_is_col ? (known >> line_idx) : (known >> (int'(line_idx) * SIZE));
    assigned_sh   = line_is_col ? (assigned >> line_idx) : (assigned >> (int'(line_idx) * SIZE));
    line_known    = line_is_col ? gather_col(known_sh) : known_sh[SIZE-1:0];
    line_assigned = line_is_col ? gather_col(assigned_sh) : assigned_sh[SIZE-1:0];
    consistent    = ((opt_cell ^ line_assigned) & line_known & len_mask) == '0;
    agree         = ~(and_acc ^ or_acc) & len_mask;
    commit_mask   = line_is_col ? (spread_col(agree) << line_idx)
                                : (CELLS'(agree) << (int'(line_idx) * SIZE));
    commit_val    = line_is_col ? (spread_col(agree & and_acc) << line_idx)
                                : (CELLS'(agree & and_acc) << (int'(line_idx) * SIZE));
  end

  // Header decode: ids below num_rows are rows, the next num_cols ids are columns.
  always_comb begin
    rows_ext   = SIZE'(rows_q);
    cols_ext   = SIZE'(cols_q);
    hdr_is_col = in_data >= rows_ext;
    hdr_bad    = in_data >= (rows_ext + cols_ext);
    col_off    = in_data[3:0] - rows_q;
    hdr_idx    = hdr_is_col ? col_off : in_data[3:0];
  end

  always_comb begin
    region = '0;
    for (int r = 0; r < SIZE; r++)
      for (int c = 0; c < SIZE; c++)
        if (r < int'(rows_q) && c < int'(cols_q)) region[r*SIZE+c] = 1'b1;
  end

  assign solved   = (rows_q != '0) && (cols_q != '0) && ((known & region) == region);
  assign in_ready = ((state == HDR) || (state == ACC)) && (!out_valid || out_ready);
  assign fire     = in_valid && in_ready;

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      rows_q      <= '0;
      cols_q      <= '0;
      line_idx    <= '0;
      line_is_col <= 1'b0;
      and_acc     <= '0;
      or_acc      <= '0;
      surv        <= '0;
      remaining   <= '0;
      known       <= '0;
      assigned    <= '0;
      out_valid   <= 1'b0;
      out_data    <= '0;
      out_hdr     <= 1'b0;
      new_cnt     <= '0;
      cnt_valid   <= 1'b0;
      err_contra  <= 1'b0;
      err_line    <= 1'b0;
    end else begin
      cnt_valid  <= 1'b0;
      err_contra <= 1'b0;
      err_line   <= 1'b0;
      if (out_valid && out_ready) out_valid <= 1'b0;

      if (start) begin
        state     <= HDR;
        rows_q    <= num_rows;
        cols_q    <= num_cols;
        known     <= '0;
        assigned  <= '0;
        out_valid <= 1'b0;
      end else begin
        case (state)
          IDLE: ;
          HDR: if (fire) begin
            if (!in_hdr || hdr_bad) begin
              err_line <= 1'b1;
            end else begin
              and_acc     <= '1;
              or_acc      <= '0;
              surv        <= '0;
              line_is_col <= hdr_is_col;
              line_idx    <= hdr_idx;
              if (in_cnt != '0) begin
                remaining <= in_cnt;
                out_valid <= 1'b1;
                out_hdr   <= 1'b1;
                out_data  <= in_data;
                state     <= ACC;
              end else begin
                state <= COMMIT;
              end
            end
          end
          ACC: if (fire) begin
            if (in_hdr) begin
              err_line <= 1'b1;
            end else begin
              if (consistent) begin
                and_acc   <= and_acc & opt_cell;
                or_acc    <= or_acc | opt_cell;
                surv      <= surv + CNT_W'(1);
                out_valid <= 1'b1;
                out_hdr   <= 1'b0;
                out_data  <= in_data;
              end
              remaining <= remaining - CNT_W'(1);
              if (remaining == CNT_W'(1)) state <= COMMIT;
            end
          end
          COMMIT: begin
            if (surv != '0) begin
              known    <= known | commit_mask;
              assigned <= (assigned & ~commit_mask) | commit_val;
            end else begin
              err_contra <= 1'b1;
            end
            new_cnt   <= surv;
            cnt_valid <= 1'b1;
            state     <= HDR;
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule
